// File: rtl/led_pattern_gen_pkg.sv
// Shared types and constants for the LED pattern generator.
// Optional feature macro used by this slice: LED_PATTERN_SYNC_EN.
package led_pattern_pkg;

  localparam logic [1:0] MODE_CODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_CODE_ON    = 2'd1;
  localparam logic [1:0] MODE_CODE_BLINK = 2'd2;
  localparam logic [1:0] MODE_CODE_PULSE = 2'd3;

  typedef enum logic [1:0] {
    MODE_OFF   = MODE_CODE_OFF,
    MODE_ON    = MODE_CODE_ON,
    MODE_BLINK = MODE_CODE_BLINK,
    MODE_PULSE = MODE_CODE_PULSE
  } led_mode_t;

  // Channel that comes out of reset blinking at DEFAULT_HALF.
  localparam int DEFAULT_CH = 0;

  // Width of a channel index; a single channel still needs one bit.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_pattern_gen_if.sv
// Configuration write port of the LED pattern generator.
// The controller drives the master side; the generator takes the slave side.
interface led_pattern_gen_if
  import led_pattern_pkg::*;
#(
  parameter int CHANNELS  = 4,
  parameter int CNT_WIDTH = 32
) ();

  localparam int CH_W = ch_width(CHANNELS);

  logic                 cfg_we;
  logic [CH_W-1:0]      cfg_ch;
  led_mode_t            cfg_mode;
  logic [CNT_WIDTH-1:0] cfg_half;

  modport master (output cfg_we, cfg_ch, cfg_mode, cfg_half);
  modport slave  (input  cfg_we, cfg_ch, cfg_mode, cfg_half);

endinterface

// File: rtl/led_pattern_gen_channel.sv
// One LED channel: mode, half-period, free-running counter and led bit.
// A load restarts the channel; clear realigns its phase without touching
// the programmed mode or half-period.
module led_channel
  import led_pattern_pkg::*;
#(
  parameter int                   CNT_WIDTH = 32,
  parameter led_mode_t            RST_MODE  = MODE_OFF,
  parameter logic [CNT_WIDTH-1:0] RST_HALF  = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  led_mode_t            mode_in,
  input  logic [CNT_WIDTH-1:0] half_in,
  input  logic                 clear,
  output logic                 led
);

  led_mode_t            mode_r;
  logic [CNT_WIDTH-1:0] half_r;
  logic [CNT_WIDTH-1:0] cnt;

  // Channel state: load beats clear, clear beats normal counting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_r <= RST_MODE;
      half_r <= RST_HALF;
      cnt    <= '0;
      led    <= 1'b0;
    end else if (load) begin
      mode_r <= mode_in;
      half_r <= half_in;
      cnt    <= '0;
      led    <= (mode_in == MODE_ON);
    end else if (clear) begin
      cnt <= '0;
      led <= (mode_r == MODE_ON);
    end else begin
      case (mode_r)
        MODE_OFF: begin
          cnt <= '0;
          led <= 1'b0;
        end
        MODE_ON: begin
          cnt <= '0;
          led <= 1'b1;
        end
        MODE_BLINK: begin
          // Compare before increment so the count never passes half_r.
          if (cnt == half_r) begin
            cnt <= '0;
            led <= ~led;
          end else begin
            cnt <= cnt + CNT_WIDTH'(1);
          end
        end
        default: begin
          if (cnt == half_r) begin
            cnt <= '0;
            led <= 1'b1;
          end else begin
            cnt <= cnt + CNT_WIDTH'(1);
            led <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator (off / on / blink / pulse per channel).
// Define LED_PATTERN_SYNC_EN to add the sync input that phase-aligns all
// channels in one cycle; without it channels align only via reset or writes.
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int                   CHANNELS     = 4,
  parameter int                   CNT_WIDTH    = 32,
  parameter logic [CNT_WIDTH-1:0] DEFAULT_HALF = CNT_WIDTH'(7999999)
) (
  input  logic                clk,
  input  logic                rst,
  led_pattern_gen_if.slave    cfg,
`ifdef LED_PATTERN_SYNC_EN
  input  logic                sync,
`endif
  output logic [CHANNELS-1:0] led
);

  localparam int CH_W = ch_width(CHANNELS);

  logic                sync_all;
  logic [CHANNELS-1:0] load;

`ifdef LED_PATTERN_SYNC_EN
  assign sync_all = sync;
`else
  assign sync_all = 1'b0;
`endif

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    // Out-of-range indices match no channel, so such writes are dropped.
    assign load[i] = cfg.cfg_we && (cfg.cfg_ch == CH_W'(i));

    led_channel #(
      .CNT_WIDTH (CNT_WIDTH),
      .RST_MODE  ((i == DEFAULT_CH) ? MODE_BLINK : MODE_OFF),
      .RST_HALF  ((i == DEFAULT_CH) ? DEFAULT_HALF : '0)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .load    (load[i]),
      .mode_in (cfg.cfg_mode),
      .half_in (cfg.cfg_half),
      .clear   (sync_all),
      .led     (led[i])
    );
  end

endmodule

// File: doc/led_pattern_gen.md
# led_pattern_gen

Parametrised multi-channel LED pattern generator driven from the PLL-derived system clock. Each channel has its own runtime-programmable mode (off, on, blink, pulse) and half-period, replacing the single fixed-rate toggling counter. It sits between the clock/PLL domain and the board LED pins, and is configured through a simple write port from a controller or from tie-offs.

## Interface
Parameters:
- `CHANNELS`, 4: number of LED channels, 1..16.
- `CNT_WIDTH`, 32: width of the per-channel counter and half-period.
- `DEFAULT_HALF`, 7999999: channel 0 half-period after reset (1 Hz blink at 16 MHz).

Ports:
- `clk` in 1: system clock (16 MHz PLL output).
- `rst` in 1: asynchronous, active-high reset.
- `cfg_we` in 1: single-cycle configuration write strobe.
- `cfg_ch` in max(1,$clog2(CHANNELS)): target channel index.
- `cfg_mode` in 2: mode code. 0 OFF, 1 ON, 2 BLINK, 3 PULSE.
- `cfg_half` in CNT_WIDTH: half-period H.
- `sync` in 1: realign all channels. Present only with `LED_PATTERN_SYNC_EN`.
- `led` out CHANNELS: registered LED drive, active-high.

## Operation
- Reset state:
  - channel 0: mode BLINK, H=`DEFAULT_HALF`.
  - all other channels: mode OFF, H=0.
  - all counters 0; `led` all 0.
- Per-channel counter: increments each cycle when mode is BLINK or PULSE. When count == H, it is a terminal event and the counter returns to 0. The period is therefore H+1 cycles. The counter holds at 0 in OFF and ON.
- OFF: `led` 0. ON: `led` 1.
- BLINK: `led` toggles on each terminal event. It is high H+1 cycles, then low H+1 cycles.
- PULSE: `led` is high for exactly the one cycle following each terminal event, otherwise low.
- H=0: BLINK toggles every cycle; PULSE is continuously high.
- Write: on a `cfg_we` cycle, the addressed channel loads mode and H, and its counter and `led` bit are cleared.
  - Exception: `led` is set to 1 if the new mode is ON.
  - Other channels are unaffected.
  - A `cfg_ch` >= `CHANNELS` is ignored.
- The arithmetic is unsigned. The counter never wraps past H, because equality is compared before increment. Writing a smaller H mid-count while the count is above the new H cannot happen, because every write clears the counter.
- Reset asserted mid-operation restores the reset state immediately, without waiting for a clock edge.

## Timing
- Write sampled at edge k:
  - ON/OFF visible on `led` after edge k.
  - BLINK first toggle, to 1, after edge k+H+1.
  - PULSE first high cycle after edge k+H+1.
- `led` is purely registered, with no combinational path from inputs to `led`.
- `cfg_we` held high for N cycles rewrites the channel N times. The channel restarts from the last write.

## Configuration
- `LED_PATTERN_SYNC_EN` defined:
  - The `sync` port exists.
  - A cycle with `sync`=1 clears every channel's counter and its BLINK/PULSE `led` bit at that edge, so all channels are phase-aligned.
  - ON channels stay 1; OFF channels stay 0.
  - If `cfg_we` occurs in the same cycle, the written channel takes its write values and the rest are synced.
- Not defined: no `sync` port; channels are aligned only by reset or by individual writes.

## Structure
- Package `led_pattern_pkg`:
  - 2-bit mode enum `led_mode_t` (MODE_OFF, MODE_ON, MODE_BLINK, MODE_PULSE).
  - Mode code constants.
  - Default-channel index 0.
- Sub-module `led_channel`, instantiated `CHANNELS` times:
  - Holds mode, H, counter and the `led` bit.
  - Inputs: load strobe, mode, H, clear.
- The top level decodes `cfg_ch` into per-channel load strobes and fans out `sync`.

## Test plan
- Reset with `DEFAULT_HALF` overridden to 3: `led[0]` goes 0 for 4 cycles, then 1 for 4 cycles, repeating; other bits stay 0.
- Write ch1 PULSE H=2 at edge k: `led[1]` high only in the cycles after edges k+3, k+6, k+9.
- Write ch2 ON at edge k: `led[2]`=1 after edge k. Then write OFF: `led[2]`=0 after the next edge.
- Write ch3 BLINK H=0: `led[3]` toggles every cycle. Write `cfg_ch`=CHANNELS: no channel changes.
- Assert `rst` asynchronously mid-blink, between edges: `led` clears immediately. On release, channel 0 restarts from count 0.
- With `LED_PATTERN_SYNC_EN`: ch0 and ch1 both BLINK H=5, but out of phase. Pulse `sync` together with a `cfg_we` write to ch2: ch0 and ch1 toggle on identical edges afterwards, and ch2 takes the written mode.
